reset_sequencer: RTL and testbench

- Central reset controller for the display design.
- Takes the board reset, applies asynchronous assertion and synchronized deassertion, holds all downstream resets for a minimum time, then releases per-block resets in a fixed order with a programmable gap.
- Also accepts a software reset request from the user logic, with a handshake, so the display pipeline can be restarted without toggling the board reset.
- Sits at the top level and drives the resets of the display driver, message logic and related blocks.

---
 rtl/reset_sequencer.sv | 112 +++++++++++
 tb/tb_reset_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Central reset controller: synchronizes board reset release, holds all stages,
// then releases per-stage resets in order; supports a handshaked soft restart.
module reset_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  soft_req,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic                  soft_ack
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam int IW      = $clog2(NUM_STAGES) + 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic            sync1;
    logic            sync2;
    logic            soft_req_d;
    logic            soft_trig;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= 1'b1;
            sync2 <= sync1;
        end
    end

    assign soft_trig = soft_req & ~soft_req_d & sync2;

    // The hold counter looks at the value rst_sync takes at this edge (sync1),
    // so the edge where rst_sync rises is itself counted as cnt=0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_ASSERT;
            cnt        <= '0;
            idx        <= '0;
            rst_out    <= '1;
            ready      <= 1'b0;
            soft_ack   <= 1'b0;
            soft_req_d <= 1'b0;
        end else begin
            soft_req_d <= soft_req;
            soft_ack   <= 1'b0;
            case (state)
                ST_ASSERT: begin
                    if (sync1) begin
                        if (cnt == HOLD_LAST) begin
                            rst_out[0] <= 1'b0;
                            idx        <= IW'(1);
                            cnt        <= '0;
                            state      <= (NUM_STAGES == 1) ? ST_RUN : ST_RELEASE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        for (int k = 0; k < NUM_STAGES; k++) begin
                            if (IW'(k) == idx) begin
                                rst_out[k] <= 1'b0;
                            end
                        end
                        idx <= idx + IW'(1);
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            state <= ST_RUN;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_RUN: begin
                    if (soft_trig) begin
                        rst_out  <= '1;
                        ready    <= 1'b0;
                        soft_ack <= 1'b1;
                        cnt      <= '0;
                        idx      <= '0;
                        state    <= ST_ASSERT;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_ASSERT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized bench for reset_sequencer: two configurations checked against an
// edge-numbered timing model of the release schedule.
module tb_reset_sequencer;

    localparam int NS_A = 3;
    localparam int HC_A = 16;
    localparam int SG_A = 4;
    localparam int NS_B = 1;
    localparam int HC_B = 1;
    localparam int SG_B = 1;

    logic            clk;
    logic            reset;
    logic            soft_req;
    logic [NS_A-1:0] rst_out_a;
    logic            ready_a;
    logic            soft_ack_a;
    logic [NS_B-1:0] rst_out_b;
    logic            ready_b;
    logic            soft_ack_b;

    int ns[2] = '{NS_A, NS_B};
    int hc[2] = '{HC_A, HC_B};
    int sg[2] = '{SG_A, SG_B};

    int cyc;
    int sync_edges;
    bit prev_req;
    int e0[2];
    bit e0_ok[2];
    bit exp_ack[2];

    int check_count;
    int error_count;

    reset_sequencer #(
        .NUM_STAGES (NS_A),
        .HOLD_CYCLES(HC_A),
        .STAGE_GAP  (SG_A)
    ) dut_a (
        .clk     (clk),
        .reset   (reset),
        .soft_req(soft_req),
        .rst_out (rst_out_a),
        .ready   (ready_a),
        .soft_ack(soft_ack_a)
    );

    reset_sequencer #(
        .NUM_STAGES (NS_B),
        .HOLD_CYCLES(HC_B),
        .STAGE_GAP  (SG_B)
    ) dut_b (
        .clk     (clk),
        .reset   (reset),
        .soft_req(soft_req),
        .rst_out (rst_out_b),
        .ready   (ready_b),
        .soft_ack(soft_ack_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h (edge %0d)", tag, actual, expected, cyc);
        end
    endtask

    function automatic int last_edge(int i);
        return e0[i] + hc[i] - 1 + (ns[i] - 1) * sg[i];
    endfunction

    // Stage k is released at edge E0 + HOLD-1 + k*GAP; count how many have passed.
    function automatic logic [31:0] exp_rst(int i);
        int el;
        int rel;
        logic [31:0] mask;
        mask = (32'd1 << ns[i]) - 32'd1;
        if (!e0_ok[i]) return mask;
        el = cyc - e0[i];
        if (el < hc[i] - 1) begin
            rel = 0;
        end else begin
            rel = 1 + (el - (hc[i] - 1)) / sg[i];
            if (rel > ns[i]) rel = ns[i];
        end
        return mask & ~((32'd1 << rel) - 32'd1);
    endfunction

    function automatic logic [31:0] exp_ready(int i);
        return (e0_ok[i] && cyc > last_edge(i)) ? 32'd1 : 32'd0;
    endfunction

    task automatic model_reset();
        sync_edges = 0;
        prev_req   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e0_ok[i]   = 1'b0;
            exp_ack[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit rise;
        cyc++;
        rise     = soft_req && !prev_req;
        prev_req = soft_req;
        if (sync_edges < 2) begin
            sync_edges++;
            if (sync_edges == 2) begin
                for (int i = 0; i < 2; i++) begin
                    e0[i]    = cyc;
                    e0_ok[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            exp_ack[i] = 1'b0;
            if (e0_ok[i] && rise && cyc > last_edge(i)) begin
                exp_ack[i] = 1'b1;
                e0[i]      = cyc + 1;
            end
        end
    endtask

    task automatic check_all();
        checkOutput("a.rst_out",  32'(rst_out_a),  exp_rst(0));
        checkOutput("a.ready",    32'(ready_a),    exp_ready(0));
        checkOutput("a.soft_ack", 32'(soft_ack_a), 32'(exp_ack[0]));
        checkOutput("b.rst_out",  32'(rst_out_b),  exp_rst(1));
        checkOutput("b.ready",    32'(ready_b),    exp_ready(1));
        checkOutput("b.soft_ack", 32'(soft_ack_b), 32'(exp_ack[1]));
    endtask

    // mode 0: soft_req low, 1: soft_req high, 2: soft_req toggles randomly.
    task automatic applyStimulus(input int n, input int mode);
        for (int c = 0; c < n; c++) begin
            case (mode)
                0: soft_req = 1'b0;
                1: soft_req = 1'b1;
                default: if ($urandom_range(0, 4) == 0) soft_req = ~soft_req;
            endcase
            @(posedge clk);
            model_step();
            #1;
            check_all();
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            check_all();
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic do_glitch();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        #1;
        reset = 1'b1;
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        cyc         = 0;
        reset       = 1'b1;
        soft_req    = 1'b0;
        model_reset();
        #2;
        reset = 1'b0;
        #1;
        check_all();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check_all();
        end
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(30, 0);
        applyStimulus(10, 1);
        applyStimulus(30, 0);
        do_reset(3);
        applyStimulus(20, 0);
        do_reset(3);
        applyStimulus(40, 0);
        do_glitch();
        applyStimulus(40, 2);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0:       do_reset($urandom_range(1, 4));
                1:       do_glitch();
                2:       applyStimulus($urandom_range(5, 40), 0);
                3:       applyStimulus($urandom_range(5, 20), 1);
                default: applyStimulus($urandom_range(5, 60), 2);
            endcase
        end
        applyStimulus(40, 0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
